// File: rtl/button_debounce_if.sv
// Button bundle between the raw push-button pins and the debounced consumers.
// The master side drives the raw levels, and the slave side (the debouncer)
// returns the debounced level and the edge pulses.
interface button_debounce_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_raw;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] btn_rise;
  logic [CHANNELS-1:0] btn_fall;
  logic                any_pressed;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_rise,
    input  btn_fall,
    input  any_pressed
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_rise,
    output btn_fall,
    output any_pressed
  );
endinterface

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer.
// Each channel first synchronises its raw input. A four-state FSM then accepts
// a level change only after the synchronised value has held steady for
// TIMER_MAX+1 consecutive samples. Any bounce returns the channel to its
// previous stable state, and the debounce starts again. The debounced level
// and its one-cycle rise/fall pulses are registered.
module button_debounce #(
  parameter logic SIMULATION      = 1'b0,
  parameter int   CHANNELS        = 4,
  parameter int   DEBOUNCE_CYCLES = 10000
) (
  input  logic               clk,
  input  logic               rst,
  button_debounce_if.slave   bus
);

  // The short timer keeps simulations fast. Valid range is 1..16383 (14-bit counter).
  localparam int          TIMER_MAX   = SIMULATION ? 10 : DEBOUNCE_CYCLES;
  localparam logic [13:0] TIMER_MAX_C = 14'(TIMER_MAX);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_e;

  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;   // synchronised button level "s"

  state_e      state_q [CHANNELS];
  state_e      state_d [CHANNELS];
  logic [13:0] cnt_q   [CHANNELS];
  logic [13:0] cnt_d   [CHANNELS];

  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q,  rise_d;
  logic [CHANNELS-1:0] fall_q,  fall_d;

  // Two-flop synchroniser on the asynchronous raw button inputs.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // State, counter and output registers. Reset forces every channel to LOW and clears all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= LOW;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Per-channel debounce FSM: next state, next count and the edge pulses.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      unique case (state_q[i])
        LOW: begin
          if (sync_q2[i]) begin
            state_d[i] = RISE_WAIT;
            cnt_d[i]   = 14'd1;
          end
        end
        RISE_WAIT: begin
          if (!sync_q2[i]) begin
            state_d[i] = LOW;
          end else if (cnt_q[i] != TIMER_MAX_C) begin
            cnt_d[i] = cnt_q[i] + 14'd1;
          end else begin
            state_d[i] = HIGH;
            level_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
          end
        end
        HIGH: begin
          if (!sync_q2[i]) begin
            state_d[i] = FALL_WAIT;
            cnt_d[i]   = 14'd1;
          end
        end
        FALL_WAIT: begin
          if (sync_q2[i]) begin
            state_d[i] = HIGH;
          end else if (cnt_q[i] != TIMER_MAX_C) begin
            cnt_d[i] = cnt_q[i] + 14'd1;
          end else begin
            state_d[i] = LOW;
            level_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
          end
        end
        default: state_d[i] = LOW;
      endcase
    end
  end

  // Registered outputs. any_pressed follows btn_level with no extra register.
  assign bus.btn_level   = level_q;
  assign bus.btn_rise    = rise_q;
  assign bus.btn_fall    = fall_q;
  assign bus.any_pressed = |level_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with SIMULATION=1 (TIMER_MAX=10) and 4 channels.
// Expected values go into a scoreboard queue when the stimulus is applied.
// They are popped and compared when the DUT output is sampled.
module tb_button_debounce;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;

  button_debounce_if #(.CHANNELS(CH)) bus ();

  button_debounce #(
    .SIMULATION      (1'b1),
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (10000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int         first;
  logic [3:0] first_vec;
  int         pulses;
  int         any_bad;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h required=none", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
    end
  endtask

  // One clock edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs for a fixed window of edges. Records the first edge (1-based) that
  // shows a masked rise/fall pulse, the pulse vector seen there, the number of
  // pulsing cycles, and how often any_pressed disagreed with btn_level.
  task automatic watch(input int window, input logic [3:0] mask, input bit on_fall,
                       output int f, output logic [3:0] fv, output int np, output int nb);
    logic [3:0] p;
    f  = -1;
    fv = '0;
    np = 0;
    nb = 0;
    for (int t = 1; t <= window; t++) begin
      tick();
      p = (on_fall ? bus.btn_fall : bus.btn_rise) & mask;
      if (p != 4'h0) begin
        np++;
        if (f < 0) begin
          f  = t;
          fv = p;
        end
      end
      if (bus.any_pressed !== (|bus.btn_level)) nb++;
    end
  endtask

  initial begin
    // Reset with every button held pressed: all outputs must stay 0.
    rst         = 1'b1;
    bus.btn_raw = 4'hF;
    push("rst_level", 32'h0);
    push("rst_rise",  32'h0);
    push("rst_fall",  32'h0);
    push("rst_any",   32'h0);
    repeat (3) tick();
    check(32'(bus.btn_level));
    check(32'(bus.btn_rise));
    check(32'(bus.btn_fall));
    check(32'(bus.any_pressed));

    // Buttons held through reset are debounced as a fresh press: level at edge 12.
    rst = 1'b0;
    push("post_rst_rise_edge",   32'd13);
    push("post_rst_rise_vec",    32'hF);
    push("post_rst_rise_pulses", 32'd1);
    push("post_rst_any_track",   32'd0);
    push("post_rst_level",       32'hF);
    watch(20, 4'hF, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(first_vec));
    check(32'(pulses));
    check(32'(any_bad));
    check(32'(bus.btn_level));

    // Release all buttons: symmetric fall latency.
    bus.btn_raw = 4'h0;
    push("rel_all_fall_edge", 32'd13);
    push("rel_all_fall_vec",  32'hF);
    push("rel_all_level",     32'h0);
    push("rel_all_any",       32'h0);
    watch(20, 4'hF, 1'b1, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(first_vec));
    check(32'(bus.btn_level));
    check(32'(bus.any_pressed));

    // Channel 0 glitch of 8 cycles is rejected; the counter returns to 0.
    bus.btn_raw = 4'b0001;
    push("short_cnt_mid",     32'd6);
    push("short_rise_high",   32'd0);
    watch(8, 4'hF, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(dut.cnt_q[0]));
    check(32'(pulses));
    bus.btn_raw = 4'b0000;
    push("short_rise_after",  32'd0);
    push("short_level",       32'h0);
    push("short_cnt_end",     32'd0);
    watch(20, 4'hF, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(pulses));
    check(32'(bus.btn_level));
    check(32'(dut.cnt_q[0]));

    // Channel 1 held 40 cycles: one rise at edge 12, one fall 12 edges after release.
    bus.btn_raw = 4'b0010;
    push("ch1_rise_edge",   32'd13);
    push("ch1_rise_pulses", 32'd1);
    push("ch1_any_track",   32'd0);
    push("ch1_level_hi",    32'b0010);
    push("ch1_any_hi",      32'd1);
    watch(40, 4'b0010, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(pulses));
    check(32'(any_bad));
    check(32'(bus.btn_level));
    check(32'(bus.any_pressed));
    bus.btn_raw = 4'b0000;
    push("ch1_fall_edge",   32'd13);
    push("ch1_fall_pulses", 32'd1);
    push("ch1_any_track_f", 32'd0);
    push("ch1_any_lo",      32'd0);
    watch(30, 4'b0010, 1'b1, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(pulses));
    check(32'(any_bad));
    check(32'(bus.any_pressed));

    // Channel 2 press with a 3-cycle bounce at cycle 6: the debounce restarts.
    bus.btn_raw = 4'b0100;
    push("ch2_pre_bounce", 32'd0);
    watch(6, 4'hF, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(pulses));
    bus.btn_raw = 4'b0000;
    push("ch2_bounce", 32'd0);
    watch(3, 4'hF, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(pulses));
    bus.btn_raw = 4'b0100;
    push("ch2_rise_edge",   32'd13);
    push("ch2_rise_vec",    32'b0100);
    push("ch2_rise_pulses", 32'd1);
    watch(30, 4'hF, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(first_vec));
    check(32'(pulses));
    bus.btn_raw = 4'b0000;
    push("ch2_fall_pulses", 32'd1);
    watch(20, 4'b0100, 1'b1, first, first_vec, pulses, any_bad);
    check(32'(pulses));

    // Reset in the middle of the channel 3 debounce (cnt=5), with the button still held.
    bus.btn_raw = 4'b1000;
    push("ch3_cnt_before_rst", 32'd5);
    repeat (7) tick();
    check(32'(dut.cnt_q[3]));
    rst = 1'b1;
    push("ch3_cnt_in_rst",   32'd0);
    push("ch3_rise_in_rst",  32'h0);
    push("ch3_level_in_rst", 32'h0);
    tick();
    check(32'(dut.cnt_q[3]));
    check(32'(bus.btn_rise));
    check(32'(bus.btn_level));
    rst = 1'b0;
    push("ch3_rise_edge",   32'd13);
    push("ch3_rise_pulses", 32'd1);
    push("ch3_level",       32'b1000);
    watch(20, 4'b1000, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(pulses));
    check(32'(bus.btn_level));
    bus.btn_raw = 4'b0000;
    push("ch3_fall_pulses", 32'd1);
    watch(20, 4'b1000, 1'b1, first, first_vec, pulses, any_bad);
    check(32'(pulses));

    // Channels 0 and 3 together: their pulses land in the same cycle.
    bus.btn_raw = 4'b1001;
    push("dual_rise_edge",   32'd13);
    push("dual_rise_vec",    32'b1001);
    push("dual_rise_pulses", 32'd1);
    push("dual_level",       32'b1001);
    watch(20, 4'hF, 1'b0, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(first_vec));
    check(32'(pulses));
    check(32'(bus.btn_level));
    bus.btn_raw = 4'b0000;
    push("dual_fall_edge", 32'd13);
    push("dual_fall_vec",  32'b1001);
    push("dual_level_lo",  32'h0);
    watch(20, 4'hF, 1'b1, first, first_vec, pulses, any_bad);
    check(32'(first));
    check(32'(first_vec));
    check(32'(bus.btn_level));

    // Every queued expectation must have been consumed.
    n_checks++;
    assert (sb_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d required=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL provide parameter SIMULATION, default 1'b0, selecting the short simulation debounce time.
REQ-002 SHALL provide parameter CHANNELS, default 4, giving the number of independent button inputs.
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 10000, giving the hardware debounce time in clk cycles.
REQ-004 SHALL derive TIMER_MAX = SIMULATION ? 10 : DEBOUNCE_CYCLES; TIMER_MAX SHALL be 1..16383.
REQ-005 SHALL have: clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have: btn_raw  input  CHANNELS  asynchronous raw push-button levels (1 = pressed).
REQ-008 SHALL have: btn_level  output  CHANNELS  debounced button level, registered.
REQ-009 SHALL have: btn_rise  output  CHANNELS  one-cycle pulse when btn_level goes 0->1, registered.
REQ-010 SHALL have: btn_fall  output  CHANNELS  one-cycle pulse when btn_level goes 1->0, registered.
REQ-011 SHALL have: any_pressed  output  1  OR of all btn_level bits.

Function
REQ-012 Each channel SHALL pass btn_raw through a two-flop synchronizer; the second flop output is s.
REQ-013 Each channel SHALL run an FSM with states LOW, RISE_WAIT, HIGH, FALL_WAIT and a 14-bit counter cnt.
REQ-014 LOW: s=1 -> RISE_WAIT, cnt<=1; else stay, cnt<=0.
REQ-015 RISE_WAIT: s=0 -> LOW, cnt<=0; s=1 and cnt!=TIMER_MAX -> cnt<=cnt+1; s=1 and cnt==TIMER_MAX -> HIGH, cnt<=0, btn_level<=1, btn_rise<=1.
REQ-016 HIGH: s=0 -> FALL_WAIT, cnt<=1; else stay, cnt<=0.
REQ-017 FALL_WAIT: s=1 -> HIGH, cnt<=0; s=0 and cnt!=TIMER_MAX -> cnt<=cnt+1; s=0 and cnt==TIMER_MAX -> LOW, cnt<=0, btn_level<=0, btn_fall<=1.
REQ-018 btn_rise/btn_fall SHALL be 0 in every cycle not named in REQ-015/REQ-017; each pulse lasts exactly one cycle.
REQ-019 Latency: with edge 0 the first edge sampling btn_raw=1 held steady, btn_level SHALL be 1 after edge TIMER_MAX+2; release symmetric.
REQ-020 Any s change shorter than TIMER_MAX+1 consecutive samples SHALL cause no change on btn_level, btn_rise, btn_fall.
REQ-021 A bounce inside RISE_WAIT/FALL_WAIT SHALL restart the debounce from the stable state (full TIMER_MAX+1 samples needed again).
REQ-022 cnt SHALL never exceed TIMER_MAX and SHALL never wrap.
REQ-023 Channels SHALL be fully independent; simultaneous pulses on several channels in one cycle SHALL all be issued.
REQ-024 any_pressed SHALL be combinational from btn_level and change in the same cycle as btn_level.

Reset
REQ-025 While rst=1 at a clk edge: synchronizer flops, cnt, btn_level, btn_rise, btn_fall SHALL load 0 and all FSMs LOW.
REQ-026 rst SHALL override all FSM activity, including mid-debounce; no pulse SHALL be issued in the cycle reset is applied.
REQ-027 A button held pressed through reset SHALL, after rst falls, be debounced as a new press and yield one btn_rise.
REQ-028 btn_level, btn_rise, btn_fall, any_pressed SHALL be 0 from the first rst edge until a debounced press completes.

Verification (SIMULATION=1, TIMER_MAX=10, CHANNELS=4)
REQ-029 rst=1 for 3 cycles with btn_raw=4'hF -> all outputs 0; after rst=0, btn_level=4'hF after 12 edges, btn_rise=4'hF for exactly one cycle.
REQ-030 btn_raw[0] high 8 cycles then low -> btn_level[0], btn_rise[0] stay 0; cnt back to 0.
REQ-031 btn_raw[1] high 40 cycles then low -> btn_level[1] high after edge 12, btn_rise[1] one pulse; btn_fall[1] one pulse 12 edges after release; any_pressed tracks btn_level[1].
REQ-032 btn_raw[2] press with a 3-cycle low bounce at cycle 6 -> btn_level[2] asserts 12 edges after the bounce ends, one btn_rise[2] only.
REQ-033 rst=1 during RISE_WAIT of btn_raw[3] (cnt=5) -> cnt=0, no pulse; held button yields btn_rise[3] 12 edges after rst falls.
REQ-034 btn_raw[0] and btn_raw[3] rise on the same edge -> btn_rise[0] and btn_rise[3] pulse in the same cycle.
